// File: rtl/mul_ctrl.sv
// Multi-cycle control stage in front of the combinational multiplier: latches
// operands, holds them for MUL_LAT cycles, then returns the selected product word.
module mul_ctrl #(
    parameter int unsigned MUL_LAT = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] rs1_data_i,
    input  logic [31:0] rs2_data_i,
    input  logic [4:0]  rd_addr_i,
    input  logic        flush_i,
    output logic        busy_o,
    output logic [31:0] mul_data1_o,
    output logic [31:0] mul_data2_o,
    output logic [2:0]  mul_op_code_o,
    input  logic [63:0] mul_res_i,
    output logic        res_valid_o,
    output logic [31:0] res_data_o,
    output logic [4:0]  rd_addr_o
);

    // Op codes understood by mul: signed x signed, signed x unsigned, unsigned x unsigned.
    localparam logic [2:0] MUL_OP_MUL   = 3'd0;
    localparam logic [2:0] MUL_OP_MULSU = 3'd1;
    localparam logic [2:0] MUL_OP_MULU  = 3'd2;

    localparam int unsigned CNT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               hi_sel_q, hi_sel_d;
    logic [31:0]        data1_q, data1_d;
    logic [31:0]        data2_q, data2_d;
    logic [2:0]         op_q, op_d;
    logic [31:0]        res_data_q, res_data_d;
    logic [4:0]         rd_addr_q, rd_addr_d;
    logic               res_valid_q, res_valid_d;
    logic               accept;

    function automatic logic [2:0] op_of(input logic [2:0] funct3);
        case (funct3[1:0])
            2'b01:   op_of = MUL_OP_MUL;
            2'b10:   op_of = MUL_OP_MULSU;
            default: op_of = MUL_OP_MULU;
        endcase
    endfunction

    always_comb begin
        accept = start_i && !funct3_i[2] && !flush_i &&
                 ((state_q == IDLE) || (state_q == DONE));
    end

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned,
        // which would otherwise infer a latch.
        state_d     = state_q;
        cnt_d       = cnt_q;
        hi_sel_d    = hi_sel_q;
        data1_d     = data1_q;
        data2_d     = data2_q;
        op_d        = op_q;
        res_data_d  = res_data_q;
        rd_addr_d   = rd_addr_q;
        res_valid_d = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                if (accept) begin
                    data1_d   = rs1_data_i;
                    data2_d   = rs2_data_i;
                    rd_addr_d = rd_addr_i;
                    op_d      = op_of(funct3_i);
                    hi_sel_d  = (funct3_i != 3'b000);
                    cnt_d     = CNT_W'(MUL_LAT - 1);
                    state_d   = CALC;
                end else begin
                    state_d = IDLE;
                end
            end
            CALC: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    res_data_d  = hi_sel_q ? mul_res_i[63:32] : mul_res_i[31:0];
                    res_valid_d = 1'b1;
                    state_d     = DONE;
                end
            end
            default: state_d = IDLE;
        endcase

        // A flush wins over everything, including a result about to be captured.
        if (flush_i) begin
            state_d     = IDLE;
            res_valid_d = 1'b0;
            res_data_d  = res_data_q;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            hi_sel_q    <= 1'b0;
            data1_q     <= '0;
            data2_q     <= '0;
            op_q        <= '0;
            res_data_q  <= '0;
            rd_addr_q   <= '0;
            res_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            hi_sel_q    <= hi_sel_d;
            data1_q     <= data1_d;
            data2_q     <= data2_d;
            op_q        <= op_d;
            res_data_q  <= res_data_d;
            rd_addr_q   <= rd_addr_d;
            res_valid_q <= res_valid_d;
        end
    end

    assign busy_o        = accept || (state_q == CALC);
    assign mul_data1_o   = data1_q;
    assign mul_data2_o   = data2_q;
    assign mul_op_code_o = op_q;
    // Suppress the strobe if a flush lands in the DONE cycle itself.
    assign res_valid_o   = res_valid_q && !flush_i;
    assign res_data_o    = res_data_q;
    assign rd_addr_o     = rd_addr_q;

endmodule
